// File: rtl/elevador_pkg.sv
// Shared types and helpers for the elevator motion/door controller.
package elevador_pkg;

   localparam int N_ANDARES  = 16;
   localparam int LARG_ANDAR = 4;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      DOOR
   } estado_t;

   typedef enum logic {
      UP,
      DOWN
   } direcao_t;

   // Bit i set when floor i lies strictly above 'andar'
   function automatic logic [N_ANDARES-1:0] mascara_acima(input logic [LARG_ANDAR-1:0] andar);
      logic [N_ANDARES-1:0] m;
      for (int i = 0; i < N_ANDARES; i++) begin
         m[i] = (i > int'(andar));
      end
      return m;
   endfunction

   // Bit i set when floor i lies strictly below 'andar'
   function automatic logic [N_ANDARES-1:0] mascara_abaixo(input logic [LARG_ANDAR-1:0] andar);
      logic [N_ANDARES-1:0] m;
      for (int i = 0; i < N_ANDARES; i++) begin
         m[i] = (i < int'(andar));
      end
      return m;
   endfunction

endpackage

// File: rtl/temporizador.sv
// Loadable down-counter; saturates at zero. Shared by travel and door dwell timing.
module temporizador #(
   parameter int LARGURA = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [LARGURA-1:0] i_valor,
   output logic               o_zero
);

   logic [LARGURA-1:0] r_contagem;

   // Load has priority; otherwise count down and hold at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_contagem <= '0;
      end else if (i_load) begin
         r_contagem <= i_valor;
      end else if (r_contagem != '0) begin
         r_contagem <= r_contagem - 1'b1;
      end
   end

   assign o_zero = (r_contagem == '0);

endmodule

// File: rtl/controle_elevador.sv
// SCAN motion and door controller for a 16-floor car.
module controle_elevador
   import elevador_pkg::*;
#(
   parameter int T_VIAGEM = 8,
   parameter int T_PORTA  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_ANDARES-1:0]  pedidos,
   output logic [LARG_ANDAR-1:0] andaratual,
   output logic                  clear,
   output logic                  pare,
   output logic                  porta_aberta,
   output logic                  subindo,
   output logic                  descendo
);

   localparam int T_MAX     = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
   localparam int LARG_TEMP = $clog2(T_MAX);
   localparam logic [LARG_TEMP-1:0] CARGA_VIAGEM = LARG_TEMP'(T_VIAGEM - 1);
   localparam logic [LARG_TEMP-1:0] CARGA_PORTA  = LARG_TEMP'(T_PORTA - 1);
   localparam logic [LARG_ANDAR-1:0] ANDAR_TOPO  = LARG_ANDAR'(N_ANDARES - 1);

   estado_t               r_estado;
   direcao_t              r_dir;
   logic [LARG_ANDAR-1:0] r_andar;
   logic                  r_clear;
   logic                  r_pare;
   logic                  r_porta;
   logic                  r_sub;
   logic                  r_des;
   logic                  r_ped_ant;

   logic                  w_acima;
   logic                  w_abaixo;
   logic                  w_ped_atual;
   logic [LARG_ANDAR-1:0] w_prox_andar;
   logic                  w_ped_prox;
   logic                  w_acima_prox;
   logic                  w_abaixo_prox;
   logic                  w_resta_dir;
   logic                  w_vai_subir;
   logic                  w_reacende;
   logic                  w_load;
   logic [LARG_TEMP-1:0]  w_valor;
   logic                  w_zero;

   assign w_acima       = |(pedidos & mascara_acima(r_andar));
   assign w_abaixo      = |(pedidos & mascara_abaixo(r_andar));
   assign w_ped_atual   = pedidos[r_andar];
   assign w_ped_prox    = pedidos[w_prox_andar];
   assign w_acima_prox  = |(pedidos & mascara_acima(w_prox_andar));
   assign w_abaixo_prox = |(pedidos & mascara_abaixo(w_prox_andar));
   assign w_resta_dir   = (r_dir == UP) ? w_acima_prox : w_abaixo_prox;
   assign w_vai_subir   = ((r_dir == UP) && w_acima) || ((r_dir == DOWN) && !w_abaixo && w_acima);
   // Only a 1->0->1 transition counts as a new press; the stale 1 after clear is ignored
   assign w_reacende    = w_ped_atual && !r_ped_ant;

   // Floor reached at the end of the current travel period, saturated at both ends
   always_comb begin
      w_prox_andar = r_andar;
      if ((r_dir == UP) && (r_andar != ANDAR_TOPO)) begin
         w_prox_andar = r_andar + 1'b1;
      end else if ((r_dir == DOWN) && (r_andar != '0)) begin
         w_prox_andar = r_andar - 1'b1;
      end
   end

   // Timer load requests, mirroring the transitions taken by the FSM below
   always_comb begin
      w_load  = 1'b0;
      w_valor = CARGA_VIAGEM;
      unique case (r_estado)
         IDLE: begin
            if (w_ped_atual) begin
               w_load  = 1'b1;
               w_valor = CARGA_PORTA;
            end else if (w_vai_subir || w_abaixo) begin
               w_load = 1'b1;
            end
         end
         MOVE: begin
            if (w_zero) begin
               if (w_ped_prox) begin
                  w_load  = 1'b1;
                  w_valor = CARGA_PORTA;
               end else if (w_resta_dir) begin
                  w_load = 1'b1;
               end
            end
         end
         DOOR: begin
            if (w_reacende) begin
               w_load  = 1'b1;
               w_valor = CARGA_PORTA;
            end
         end
         default: ;
      endcase
   end

   temporizador #(
      .LARGURA (LARG_TEMP)
   ) u_temporizador (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_valor (w_valor),
      .o_zero  (w_zero)
   );

   // Main FSM: state, direction, floor and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado  <= IDLE;
         r_dir     <= UP;
         r_andar   <= '0;
         r_clear   <= 1'b0;
         r_pare    <= 1'b1;
         r_porta   <= 1'b0;
         r_sub     <= 1'b0;
         r_des     <= 1'b0;
         r_ped_ant <= 1'b0;
      end else begin
         r_clear <= 1'b0;
         unique case (r_estado)
            IDLE: begin
               if (w_ped_atual) begin
                  r_estado  <= DOOR;
                  r_clear   <= 1'b1;
                  r_porta   <= 1'b1;
                  r_ped_ant <= 1'b1;
               end else if (w_vai_subir) begin
                  r_estado <= MOVE;
                  r_dir    <= UP;
                  r_pare   <= 1'b0;
                  r_sub    <= 1'b1;
                  r_des    <= 1'b0;
               end else if (w_abaixo) begin
                  r_estado <= MOVE;
                  r_dir    <= DOWN;
                  r_pare   <= 1'b0;
                  r_sub    <= 1'b0;
                  r_des    <= 1'b1;
               end
            end
            MOVE: begin
               if (w_zero) begin
                  r_andar <= w_prox_andar;
                  if (w_ped_prox) begin
                     r_estado  <= DOOR;
                     r_clear   <= 1'b1;
                     r_porta   <= 1'b1;
                     r_pare    <= 1'b1;
                     r_sub     <= 1'b0;
                     r_des     <= 1'b0;
                     r_ped_ant <= 1'b1;
                  end else if (!w_resta_dir) begin
                     // Nothing ahead: stop and let IDLE decide whether to reverse
                     r_estado <= IDLE;
                     r_pare   <= 1'b1;
                     r_sub    <= 1'b0;
                     r_des    <= 1'b0;
                  end
               end
            end
            DOOR: begin
               r_ped_ant <= w_ped_atual;
               if (w_reacende) begin
                  r_clear <= 1'b1;
               end else if (w_zero) begin
                  r_estado <= IDLE;
                  r_porta  <= 1'b0;
               end
            end
            default: begin
               r_estado <= IDLE;
               r_pare   <= 1'b1;
               r_porta  <= 1'b0;
               r_sub    <= 1'b0;
               r_des    <= 1'b0;
            end
         endcase
      end
   end

   assign andaratual   = r_andar;
   assign clear        = r_clear;
   assign pare         = r_pare;
   assign porta_aberta = r_porta;
   assign subindo      = r_sub;
   assign descendo     = r_des;

endmodule
